uart_cmd_parser: RTL and testbench

//   Downstream consumer of the UART receiver. Collects ASCII bytes into a line buffer and parses

---
 rtl/uart_cmd_parser_pkg.sv | 41 ++++
 rtl/uart_cmd_parser_if.sv | 24 ++
 rtl/uart_cmd_parser_codec.sv | 31 +++
 rtl/uart_cmd_parser.sv | 161 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser: FSM states, reply ids,
// ASCII codes and the last index of each reply string.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    EXEC,
    TX_LOAD,
    TX_BUSY,
    TX_DONE
  } state_t;

  typedef enum logic [1:0] {
    RPL_OK,
    RPL_ERR,
    RPL_RB
  } reply_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;

  // Index of the final byte of each reply ("OK\r\n", "E\r\n", "hh\r\n").
  localparam logic [1:0] LAST_IDX_OK  = 2'd3;
  localparam logic [1:0] LAST_IDX_ERR = 2'd2;
  localparam logic [1:0] LAST_IDX_RB  = 2'd3;

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  // Letter compare ignoring case; bit 5 is the only ASCII case bit.
  function automatic logic is_letter(input logic [7:0] b, input logic [7:0] upper);
    return (b | 8'h20) == (upper | 8'h20);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-level link between the UART RX/TX blocks and the command parser.
// master = UART side (drives received bytes and TX status), slave = parser.
interface uart_cmd_if #(
  parameter int LED_W = 6
) ();
  logic             rx_byte_ready_i;
  logic [7:0]       rx_data_i;
  logic [7:0]       tx_data_o;
  logic             tx_trigger_o;
  logic             tx_complete_i;
  logic [LED_W-1:0] led_o;
  logic             cmd_err_o;
  logic             rx_drop_o;

  modport master (
    output rx_byte_ready_i, rx_data_i, tx_complete_i,
    input  tx_data_o, tx_trigger_o, led_o, cmd_err_o, rx_drop_o
  );

  modport slave (
    input  rx_byte_ready_i, rx_data_i, tx_complete_i,
    output tx_data_o, tx_trigger_o, led_o, cmd_err_o, rx_drop_o
  );
endinterface

// File: rtl/uart_cmd_parser_codec.sv
// Combinational hex helper: ASCII char -> {valid, nibble}; with UART_CMD_READBACK_EN
// also nibble -> uppercase ASCII hex digit.
module hex_ascii_codec (
  input  logic [7:0] ch,
  output logic       ch_valid,
  output logic [3:0] ch_nibble
`ifdef UART_CMD_READBACK_EN
  ,
  input  logic [3:0] nibble,
  output logic [7:0] ascii
`endif
);

  always_comb begin
    ch_valid  = 1'b0;
    ch_nibble = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      ch_valid  = 1'b1;
      ch_nibble = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15.
      ch_valid  = 1'b1;
      ch_nibble = ch[3:0] + 4'd9;
    end
  end

`ifdef UART_CMD_READBACK_EN
  assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
`endif

endmodule

// File: rtl/uart_cmd_parser.sv
// Line-buffered ASCII command parser: "Lhh" sets the LEDs, replies go out byte by byte
// over the TX trigger/complete handshake. Optional "R" readback: UART_CMD_READBACK_EN.
module uart_cmd_parser #(
  parameter int MAX_LEN = 8,
  parameter int LED_W   = 6
) (
  input logic       clk_i,
  input logic       rst_n_i,
  uart_cmd_if.slave bus
);
  import uart_cmd_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t           state_reg;
  logic [LEN_W-1:0] len_reg;
  logic             ovf_reg;
  reply_t           reply_reg;
  logic [1:0]       idx_reg;
  logic [LED_W-1:0] led_reg;
  logic [7:0]       tx_data_reg;
  logic             trig_reg;
  logic             err_reg;
  logic             drop_reg;
  logic [7:0]       line_buf [MAX_LEN];

  logic       buf_wr;
  logic [1:0] dig_valid;
  logic [3:0] dig_nibble [2];
  logic       cmd_led;
  logic       cmd_rb;
  logic [1:0] last_idx;
  logic [7:0] rom [4];
  logic [7:0] rom_byte;

`ifdef UART_CMD_READBACK_EN
  logic [7:0] led_ext;
  logic [3:0] rb_nibble [2];
  logic [7:0] rb_ascii [2];
  assign led_ext = 8'(led_reg);
`endif

  // Digits of an "Lhh" command sit at buf[1] and buf[2]; codec gi handles buf[gi+1].
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_codec
`ifdef UART_CMD_READBACK_EN
      assign rb_nibble[gi] = led_ext[7-4*gi -: 4];
`endif
      hex_ascii_codec u_codec (
        .ch        (line_buf[gi+1]),
        .ch_valid  (dig_valid[gi]),
        .ch_nibble (dig_nibble[gi])
`ifdef UART_CMD_READBACK_EN
        ,
        .nibble    (rb_nibble[gi]),
        .ascii     (rb_ascii[gi])
`endif
      );
    end
  endgenerate

  assign cmd_led = !ovf_reg && (len_reg == LEN_W'(3)) && is_letter(line_buf[0], ASCII_L)
                   && (&dig_valid);
`ifdef UART_CMD_READBACK_EN
  assign cmd_rb = !ovf_reg && (len_reg == LEN_W'(1)) && is_letter(line_buf[0], ASCII_R);
`else
  assign cmd_rb = 1'b0;
`endif

  always_comb begin
    rom = '{default: 8'h00};
    case (reply_reg)
      RPL_OK:  rom = '{ASCII_O, ASCII_K, ASCII_CR, ASCII_LF};
`ifdef UART_CMD_READBACK_EN
      RPL_RB:  rom = '{rb_ascii[0], rb_ascii[1], ASCII_CR, ASCII_LF};
`endif
      default: rom = '{ASCII_E, ASCII_CR, ASCII_LF, 8'h00};
    endcase
    rom_byte = rom[idx_reg];
  end

  assign last_idx = (reply_reg == RPL_OK)  ? LAST_IDX_OK :
                    (reply_reg == RPL_ERR) ? LAST_IDX_ERR : LAST_IDX_RB;

  assign buf_wr = (state_reg == COLLECT) && bus.rx_byte_ready_i && !is_term(bus.rx_data_i)
                  && (len_reg < LEN_MAX);

  always_ff @(posedge clk_i) begin
    if (buf_wr) line_buf[len_reg[IDX_W-1:0]] <= bus.rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg   <= COLLECT;
      len_reg     <= '0;
      ovf_reg     <= 1'b0;
      reply_reg   <= RPL_OK;
      idx_reg     <= 2'd0;
      led_reg     <= '0;
      tx_data_reg <= 8'h00;
      trig_reg    <= 1'b0;
      err_reg     <= 1'b0;
      drop_reg    <= 1'b0;
    end else begin
      trig_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (bus.rx_byte_ready_i && state_reg != COLLECT) drop_reg <= 1'b1;
      case (state_reg)
        COLLECT: if (bus.rx_byte_ready_i) begin
          // Empty-line terminators are ignored so CRLF yields a single command.
          if (is_term(bus.rx_data_i)) begin
            if (len_reg != '0) state_reg <= EXEC;
          end else if (len_reg < LEN_MAX) begin
            len_reg <= len_reg + LEN_W'(1);
          end else begin
            ovf_reg <= 1'b1;
          end
        end
        EXEC: begin
          len_reg   <= '0;
          ovf_reg   <= 1'b0;
          idx_reg   <= 2'd0;
          state_reg <= TX_LOAD;
          if (cmd_led) begin
            led_reg   <= LED_W'({dig_nibble[0], dig_nibble[1]});
            reply_reg <= RPL_OK;
          end else if (cmd_rb) begin
            reply_reg <= RPL_RB;
          end else begin
            reply_reg <= RPL_ERR;
            err_reg   <= 1'b1;
          end
        end
        TX_LOAD: if (bus.tx_complete_i) begin
          tx_data_reg <= rom_byte;
          trig_reg    <= 1'b1;
          state_reg   <= TX_BUSY;
        end
        TX_BUSY: if (!bus.tx_complete_i) state_reg <= TX_DONE;
        TX_DONE: if (bus.tx_complete_i) begin
          if (idx_reg == last_idx) begin
            state_reg <= COLLECT;
          end else begin
            idx_reg   <= idx_reg + 2'd1;
            state_reg <= TX_LOAD;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign bus.tx_data_o    = tx_data_reg;
  assign bus.tx_trigger_o = trig_reg;
  assign bus.led_o        = led_reg;
  assign bus.cmd_err_o    = err_reg;
  assign bus.rx_drop_o    = drop_reg;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected reply bytes are queued with each command
// and popped by a transmitter model that holds tx_complete_i low for 10 cycles per byte.
module tb_uart_cmd_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_if #(.LED_W(6)) bus ();

  uart_cmd_parser #(.MAX_LEN(8), .LED_W(6)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int trig_cyc = 0;
  int err_cyc = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse-width monitors: every high cycle is counted, so a stretched pulse shows up.
  initial forever begin
    @(posedge clk); #1;
    if (bus.tx_trigger_o) trig_cyc++;
    if (bus.cmd_err_o) err_cyc++;
  end

  // Transmitter model: accepts a trigger, checks the byte, then stays busy 10 cycles.
  initial begin
    bus.tx_complete_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.tx_trigger_o) begin
        if (exp_q.size() == 0) begin
          check("extra_trigger", 32'(exp_q.size()), 32'd1);
        end else begin
          $display("[TB] tx byte 0x%02h", bus.tx_data_o);
          check("tx_byte", 32'(bus.tx_data_o), 32'(exp_q.pop_front()));
        end
        bus.tx_complete_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk);
          if (!rst_n) break;
        end
        #1 bus.tx_complete_i = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data_i = b;
    bus.rx_byte_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rx_byte_ready_i = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_crlf();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_ok();
    push_str("OK");
    push_crlf();
  endtask

  task automatic push_err();
    push_str("E");
    push_crlf();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && bus.tx_complete_i) break;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  int trig0;
  int err0;

  initial begin
    bus.rx_byte_ready_i = 1'b0;
    bus.rx_data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", 32'(bus.led_o), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data_o), 32'h0);
    check("rst_trig", 32'(bus.tx_trigger_o), 32'h0);
    check("rst_err", 32'(bus.cmd_err_o), 32'h0);
    check("rst_drop", 32'(bus.rx_drop_o), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "L15\r" with latency check, then the trailing LF alone must be ignored.
    $display("[TB] cmd L15 CR LF");
    trig0 = trig_cyc; err0 = err_cyc;
    push_ok();
    send_str("L15");
    send_byte(8'h0D);
    @(posedge clk); #1;
    check("lat_exec_no_trig", 32'(bus.tx_trigger_o), 32'h0);
    @(posedge clk); #1;
    check("lat_first_trig", 32'(bus.tx_trigger_o), 32'h1);
    wait_idle("l15_done");
    check("l15_led", 32'(bus.led_o), 32'h15);
    send_byte(8'h0A);
    repeat (20) @(posedge clk);
    #1;
    check("l15_trig_cnt", 32'(trig_cyc - trig0), 32'd4);
    check("l15_no_err", 32'(err_cyc - err0), 32'd0);

    $display("[TB] cmd lff LF");
    push_ok();
    send_str("lff\n");
    wait_idle("lff_done");
    check("lff_led", 32'(bus.led_o), 32'h3F);

    $display("[TB] cmd LG1 CR");
    err0 = err_cyc;
    push_err();
    send_str("LG1");
    send_byte(8'h0D);
    wait_idle("lg1_done");
    check("lg1_err", 32'(err_cyc - err0), 32'd1);
    check("lg1_led", 32'(bus.led_o), 32'h3F);

    $display("[TB] cmd L12345678 LF (overflow)");
    err0 = err_cyc;
    push_err();
    send_str("L12345678\n");
    wait_idle("ovf_done");
    check("ovf_err", 32'(err_cyc - err0), 32'd1);
    check("ovf_led", 32'(bus.led_o), 32'h3F);
    push_ok();
    send_str("L01\n");
    wait_idle("l01_done");
    check("l01_led", 32'(bus.led_o), 32'h01);
    check("drop_clear", 32'(bus.rx_drop_o), 32'h0);

    $display("[TB] cmd L2A LF with bytes during reply");
    trig0 = trig_cyc;
    push_ok();
    send_str("L2A\n");
    send_str("L33\n");
    wait_idle("drop_done");
    check("drop_set", 32'(bus.rx_drop_o), 32'h1);
    check("drop_led", 32'(bus.led_o), 32'h2A);
    check("drop_trig_cnt", 32'(trig_cyc - trig0), 32'd4);

    $display("[TB] cmd R LF");
    err0 = err_cyc;
`ifdef UART_CMD_READBACK_EN
    push_str("2A");
    push_crlf();
    send_str("R\n");
    wait_idle("rb_done");
    check("rb_no_err", 32'(err_cyc - err0), 32'd0);
`else
    push_err();
    send_str("R\n");
    wait_idle("rb_done");
    check("rb_err", 32'(err_cyc - err0), 32'd1);
`endif

    $display("[TB] cmd L3C LF with reset mid-reply");
    trig0 = trig_cyc;
    push_ok();
    send_str("L3C\n");
    for (int i = 0; i < 500; i++) begin
      if (trig_cyc - trig0 >= 2) break;
      @(posedge clk); #1;
    end
    check("mid_two_trigs", 32'(trig_cyc - trig0), 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mid_rst_led", 32'(bus.led_o), 32'h0);
    check("mid_rst_tx_data", 32'(bus.tx_data_o), 32'h0);
    check("mid_rst_trig", 32'(bus.tx_trigger_o), 32'h0);
    check("mid_rst_err", 32'(bus.cmd_err_o), 32'h0);
    check("mid_rst_drop", 32'(bus.rx_drop_o), 32'h0);
    rst_n = 1'b1;
    trig0 = trig_cyc;
    repeat (40) @(posedge clk);
    #1;
    check("mid_no_trig_after_rst", 32'(trig_cyc - trig0), 32'd0);

    $display("[TB] cmd L07 LF after reset");
    push_ok();
    send_str("L07\n");
    wait_idle("l07_done");
    check("l07_led", 32'(bus.led_o), 32'h07);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
